// File: rtl/bifrost_boot_pkg.sv
// ----------------------------------------------------------------------------
// bifrost_boot_pkg: shared types and constants for the 6502 boot sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package bifrost_boot_pkg;

    typedef enum logic [2:0] {
        ST_HOLD     = 3'd0,
        ST_WAIT_VEC = 3'd1,
        ST_VEC_HI   = 3'd2,
        ST_SLED     = 3'd3,
        ST_DONE     = 3'd4,
        ST_FAULT    = 3'd5
    } boot_state_e;

    localparam logic [15:0] RESET_VEC_LO       = 16'hFFFC;
    localparam logic [15:0] RESET_VEC_HI       = 16'hFFFD;
    localparam logic [7:0]  NOP_OPCODE_DEFAULT = 8'hEA;

    // Counter width that can hold the terminal value itself.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/boot_sequencer_sled_checker.sv
// ----------------------------------------------------------------------------
// sled_checker: tracks expected PC through the NOP sled, flags bad fetches
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sled_checker
    import bifrost_boot_pkg::*;
#(
    parameter logic [15:0] VECTOR      = 16'hE000,
    parameter int unsigned SLED_LENGTH = 16
) (
    input  logic        clock,
    input  logic        reset_b,
    input  logic        en_i,
    input  logic [15:0] addr_i,
    input  logic        rw_i,
    input  logic        sync_i,
    output logic        fault_o,
    output logic        complete_o
);

    localparam int unsigned      CNT_W    = cnt_width(SLED_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLED_LENGTH);

    logic [15:0]      exp_pc_q;
    logic [15:0]      exp_pc_d;
    logic [CNT_W-1:0] fetch_cnt_q;
    logic [CNT_W-1:0] fetch_cnt_d;
    logic             fetch_hit;
    logic             checking;

    assign complete_o = (fetch_cnt_q >= CNT_LAST);
    assign checking   = en_i && !complete_o;
    assign fetch_hit  = checking && sync_i && rw_i && (addr_i == exp_pc_q);
    // Non-sync reads are the 6502 dummy operand reads and are left unchecked.
    assign fault_o    = checking && (!rw_i || (sync_i && (addr_i != exp_pc_q)));

    always_comb begin
        exp_pc_d    = exp_pc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (!en_i) begin
            exp_pc_d    = VECTOR;
            fetch_cnt_d = '0;
        end else if (fetch_hit) begin
            exp_pc_d    = exp_pc_q + 16'd1;
            fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            exp_pc_q    <= VECTOR;
            fetch_cnt_q <= '0;
        end else begin
            exp_pc_q    <= exp_pc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/boot_sequencer.sv
// ----------------------------------------------------------------------------
// boot_sequencer: holds/releases 6502 reset, serves reset vector and NOP sled
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module boot_sequencer
    import bifrost_boot_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 8,
    parameter logic [15:0] VECTOR         = 16'hE000,
    parameter logic [7:0]  NOP_OPCODE     = NOP_OPCODE_DEFAULT,
    parameter int unsigned SLED_LENGTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset_b,
    input  logic [15:0] addr,
    input  logic        rw,
    input  logic        sync,
    input  logic        restart,
    output logic [7:0]  data_out,
    output logic        data_oe,
    output logic        cpu_resb,
    output logic        done,
    output logic        error
);

    localparam int unsigned       HOLD_W    = cnt_width(RESET_CYCLES);
    localparam int unsigned       TMO_W     = cnt_width(TIMEOUT_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    boot_state_e       state_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              cpu_resb_q;
    logic              done_q;
    logic              error_q;

    logic              vec_lo_hit;
    logic              vec_hi_hit;
    logic              sled_en;
    logic              sled_fault;
    logic              sled_complete;

    assign vec_lo_hit = rw && (addr == RESET_VEC_LO);
    assign vec_hi_hit = rw && (addr == RESET_VEC_HI);
    assign sled_en    = (state_q == ST_SLED);

    sled_checker #(
        .VECTOR      (VECTOR),
        .SLED_LENGTH (SLED_LENGTH)
    ) u_sled_checker (
        .clock      (clock),
        .reset_b    (reset_b),
        .en_i       (sled_en),
        .addr_i     (addr),
        .rw_i       (rw),
        .sync_i     (sync),
        .fault_o    (sled_fault),
        .complete_o (sled_complete)
    );

    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
            tmo_cnt_q  <= '0;
            cpu_resb_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q >= HOLD_LAST) begin
                        state_q    <= ST_WAIT_VEC;
                        cpu_resb_q <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                    end
                end
                ST_WAIT_VEC: begin
                    if (vec_lo_hit) begin
                        state_q <= ST_VEC_HI;
                    end else if (tmo_cnt_q >= TMO_LAST) begin
                        state_q    <= ST_FAULT;
                        error_q    <= 1'b1;
                        cpu_resb_q <= 1'b0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                ST_VEC_HI: begin
                    if (vec_hi_hit) begin
                        state_q <= ST_SLED;
                    end else begin
                        state_q    <= ST_FAULT;
                        error_q    <= 1'b1;
                        cpu_resb_q <= 1'b0;
                    end
                end
                ST_SLED: begin
                    // A verified sled wins over anything seen on the extra cycle.
                    if (sled_complete) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else if (sled_fault) begin
                        state_q    <= ST_FAULT;
                        error_q    <= 1'b1;
                        cpu_resb_q <= 1'b0;
                    end
                end
                ST_DONE, ST_FAULT: begin
                    if (restart) begin
                        state_q    <= ST_HOLD;
                        hold_cnt_q <= '0;
                        tmo_cnt_q  <= '0;
                        cpu_resb_q <= 1'b0;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_HOLD;
                    cpu_resb_q <= 1'b0;
                end
            endcase
        end
    end

    // Bus response is combinational so it lands inside the current CPU cycle.
    always_comb begin
        data_out = NOP_OPCODE;
        data_oe  = 1'b0;
        case (state_q)
            ST_WAIT_VEC: begin
                data_oe = rw;
                if (vec_lo_hit) data_out = VECTOR[7:0];
            end
            ST_VEC_HI: begin
                data_oe = rw;
                if (vec_hi_hit) data_out = VECTOR[15:8];
            end
            ST_SLED: data_oe = rw;
            default: data_oe = 1'b0;
        endcase
    end

    assign cpu_resb = cpu_resb_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_sequencer.sv
// ----------------------------------------------------------------------------
// tb_boot_sequencer: directed vector bench for boot_sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_boot_sequencer;

    logic        clock = 1'b0;
    logic        reset_b;
    logic [15:0] addr;
    logic        rw;
    logic        sync;
    logic        restart;

    logic [7:0]  d1_out;
    logic        d1_oe, d1_resb, d1_done, d1_err;
    logic [7:0]  d2_out;
    logic        d2_oe, d2_resb, d2_done, d2_err;

    always #5 clock = ~clock;

    boot_sequencer dut (
        .clock    (clock),
        .reset_b  (reset_b),
        .addr     (addr),
        .rw       (rw),
        .sync     (sync),
        .restart  (restart),
        .data_out (d1_out),
        .data_oe  (d1_oe),
        .cpu_resb (d1_resb),
        .done     (d1_done),
        .error    (d1_err)
    );

    boot_sequencer #(
        .RESET_CYCLES (2),
        .VECTOR       (16'hFFFF),
        .SLED_LENGTH  (3)
    ) dut_w (
        .clock    (clock),
        .reset_b  (reset_b),
        .addr     (addr),
        .rw       (rw),
        .sync     (sync),
        .restart  (restart),
        .data_out (d2_out),
        .data_oe  (d2_oe),
        .cpu_resb (d2_resb),
        .done     (d2_done),
        .error    (d2_err)
    );

    typedef struct {
        logic        sel;
        logic [15:0] addr;
        logic        rw;
        logic        sync;
        logic        restart;
        logic [7:0]  dout;
        logic        oe;
        logic        resb;
        logic        done;
        logic        err;
    } vec_t;

    vec_t q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   vec_idx = 0;

    localparam logic [7:0] NOP = 8'hEA;

    task automatic check(input string name, input logic sel, input logic [7:0] edout,
                         input logic eoe, input logic eresb, input logic edone, input logic eerr);
        logic [11:0] got;
        logic [11:0] exp;
        got = sel ? {d2_out, d2_oe, d2_resb, d2_done, d2_err}
                  : {d1_out, d1_oe, d1_resb, d1_done, d1_err};
        exp = {edout, eoe, eresb, edone, eerr};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got dout=%h oe=%b resb=%b done=%b err=%b, expected dout=%h oe=%b resb=%b done=%b err=%b",
                     name, got[11:4], got[3], got[2], got[1], got[0],
                     edout, eoe, eresb, edone, eerr);
        end
    endtask

    function automatic void push(input logic sel, input logic [15:0] a, input logic r,
                                 input logic s, input logic rs, input logic [7:0] d,
                                 input logic oe, input logic resb, input logic dn, input logic er);
        vec_t v;
        v.sel = sel; v.addr = a; v.rw = r; v.sync = s; v.restart = rs;
        v.dout = d; v.oe = oe; v.resb = resb; v.done = dn; v.err = er;
        q.push_back(v);
    endfunction

    function automatic void push_hold(input logic sel, input int n);
        for (int i = 0; i < n; i++) push(sel, 16'h0000, 1, 0, 0, NOP, 0, 0, 0, 0);
    endfunction

    function automatic void push_wait(input logic sel);
        push(sel, 16'h0000, 1, 0, 0, NOP, 1, 1, 0, 0);
    endfunction

    function automatic void push_boot_main();
        push_hold(0, 8);
        push_wait(0);
        push(0, 16'h01FF, 0, 0, 0, NOP,   0, 1, 0, 0);
        push(0, 16'h01FE, 0, 0, 0, NOP,   0, 1, 0, 0);
        push(0, 16'hFFFC, 1, 0, 0, 8'h00, 1, 1, 0, 0);
        push(0, 16'hFFFD, 1, 0, 0, 8'hE0, 1, 1, 0, 0);
    endfunction

    function automatic void push_sled_full();
        for (int k = 0; k < 16; k++) begin
            push(0, 16'hE000 + 16'(k),     1, 1, 0, NOP, 1, 1, 0, 0);
            push(0, 16'hE000 + 16'(k + 1), 1, 0, 0, NOP, 1, 1, 0, 0);
        end
        push(0, 16'h0000, 1, 0, 0, NOP, 0, 1, 1, 0);
    endfunction

    function automatic void push_fault_restart();
        push(0, 16'h0000, 1, 0, 0, NOP, 0, 0, 0, 1);
        push(0, 16'h0000, 1, 0, 1, NOP, 0, 0, 0, 1);
    endfunction

    task automatic run_vectors();
        foreach (q[i]) begin
            @(negedge clock);
            addr    = q[i].addr;
            rw      = q[i].rw;
            sync    = q[i].sync;
            restart = q[i].restart;
            #1;
            check($sformatf("vec%0d", vec_idx), q[i].sel, q[i].dout, q[i].oe,
                  q[i].resb, q[i].done, q[i].err);
            vec_idx++;
        end
        q.delete();
    endtask

    task automatic release_reset();
        @(posedge clock);
        #2 reset_b = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_b = 1'b0; addr = 16'h0000; rw = 1'b1; sync = 1'b0; restart = 1'b0;
        #2;
        check("reset_main", 0, NOP, 0, 0, 0, 0);
        check("reset_wrap", 1, NOP, 0, 0, 0, 0);
        release_reset();

        // Full boot, sled, done, then restart into a mismatched sled
        push_boot_main();
        push_sled_full();
        push(0, 16'h0000, 1, 0, 1, NOP, 0, 1, 1, 0);
        push_boot_main();
        for (int k = 0; k < 4; k++) push(0, 16'hE000 + 16'(k), 1, 1, 0, NOP, 1, 1, 0, 0);
        push(0, 16'hE005, 1, 1, 0, NOP, 1, 1, 0, 0);
        push_fault_restart();

        // Vector-fetch timeout, with a premature $FFFD read and a write inside
        push_hold(0, 8);
        for (int j = 0; j < 64; j++) begin
            if (j == 10)      push(0, 16'hFFFD, 1, 0, 0, NOP, 1, 1, 0, 0);
            else if (j == 20) push(0, 16'h01FD, 0, 0, 0, NOP, 0, 1, 0, 0);
            else              push(0, 16'h0000, 1, 0, 0, NOP, 1, 1, 0, 0);
        end
        push_fault_restart();

        // Wrong access right after the low vector byte
        push_hold(0, 8);
        push_wait(0);
        push(0, 16'hFFFC, 1, 0, 0, 8'h00, 1, 1, 0, 0);
        push(0, 16'h0000, 1, 0, 0, NOP,   1, 1, 0, 0);
        push_fault_restart();

        // Write during the sled
        push_boot_main();
        push(0, 16'hE000, 1, 1, 0, NOP, 1, 1, 0, 0);
        push(0, 16'h01FF, 0, 0, 0, NOP, 0, 1, 0, 0);
        push_fault_restart();

        // Partial sled ahead of an asynchronous reset
        push_boot_main();
        push(0, 16'hE000, 1, 1, 0, NOP, 1, 1, 0, 0);
        push(0, 16'hE001, 1, 0, 0, NOP, 1, 1, 0, 0);
        push(0, 16'hE001, 1, 1, 0, NOP, 1, 1, 0, 0);
        run_vectors();

        @(negedge clock);
        addr = 16'hE002; rw = 1'b1; sync = 1'b1; restart = 1'b0;
        #1;
        check("mid_sled_pre", 0, NOP, 1, 1, 0, 0);
        reset_b = 1'b0;
        #1;
        check("mid_sled_async_rst", 0, NOP, 0, 0, 0, 0);
        release_reset();

        push_boot_main();
        push_sled_full();
        run_vectors();

        // PC wrap with VECTOR=$FFFF and a three-fetch sled
        @(negedge clock);
        reset_b = 1'b0;
        release_reset();
        push_hold(1, 2);
        push_wait(1);
        push(1, 16'hFFFC, 1, 0, 0, 8'hFF, 1, 1, 0, 0);
        push(1, 16'hFFFD, 1, 0, 0, 8'hFF, 1, 1, 0, 0);
        push(1, 16'hFFFF, 1, 1, 0, NOP,   1, 1, 0, 0);
        push(1, 16'h0000, 1, 1, 0, NOP,   1, 1, 0, 0);
        push(1, 16'h0001, 1, 1, 0, NOP,   1, 1, 0, 0);
        push(1, 16'h0002, 1, 0, 0, NOP,   1, 1, 0, 0);
        push(1, 16'h0000, 1, 0, 0, NOP,   0, 1, 1, 0);
        run_vectors();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
